// File: rtl/rst_sync_pkg.sv
// Shared definitions for the cross-domain reset path: controller state
// encoding, synchronizer depth floor and a width helper.
package rst_sync_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSERT   = 3'd1,
    WAIT_ACK = 3'd2,
    RELEASE  = 3'd3,
    FINISH   = 3'd4
  } state_t;

  localparam int SYNC_MIN_STAGES = 2;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer: a chain of flops that brings an asynchronous
// level into the clk domain. Depth below the safe floor is raised to it.
module bit_sync
  import rst_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int STAGES = (NUM_STAGES < SYNC_MIN_STAGES) ? SYNC_MIN_STAGES : NUM_STAGES;

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_req_ctrl.sv
// Initiator side of the cross-domain reset handshake. Drives a stretched
// reset to the remote domain, waits for the remote synchronized reset to
// come back asserted, releases, waits for it to drop and reports DONE.
// Either wait that exceeds TIMEOUT cycles raises the sticky ERR flag.
module rst_req_ctrl
  import rst_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int MIN_ASSERT = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack_async,
  output logic rst_out,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ack_s;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_async),
    .q  (ack_s)
  );

  // Handshake sequencer; all outputs are registered here so nothing
  // combinational from req or ack_async reaches a port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ASSERT;
      cnt     <= '0;
      rst_out <= 1'b1;
      busy    <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state   <= ASSERT;
            cnt     <= '0;
            err     <= 1'b0;
            rst_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            state <= WAIT_ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_s) begin
            state   <= RELEASE;
            cnt     <= '0;
            rst_out <= 1'b0;
          end else if (cnt == TIMEOUT_LAST) begin
            state   <= RELEASE;
            cnt     <= '0;
            rst_out <= 1'b0;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            state <= FINISH;
            cnt   <= '0;
            done  <= ~err;
          end else if (cnt == TIMEOUT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rst_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Bench for rst_req_ctrl: directed scenarios followed by randomized
// request/reset/remote behaviour, checked every cycle against a
// phase-and-elapsed-time model of the handshake.
module tb_rst_req_ctrl;

  localparam int NS = 2;
  localparam int MA = 4;
  localparam int TO = 32;

  localparam int PH_IDLE   = 0;
  localparam int PH_STRECH = 1;
  localparam int PH_WAIT   = 2;
  localparam int PH_DROP   = 3;
  localparam int PH_END    = 4;

  localparam int RM_LOOP  = 0;
  localparam int RM_LOW   = 1;
  localparam int RM_HIGH  = 2;
  localparam int RM_NOISE = 3;

  logic clk;
  logic rst;
  logic req;
  logic ack_async;
  logic rst_out;
  logic busy;
  logic done;
  logic err;

  int compared;
  int mismatched;
  int cycle;

  int phase;
  int age;
  bit m_err;
  bit m_sync [NS];
  bit hist [8];
  int m_done_cnt;
  int dut_done_cnt;

  int remote_mode;
  int remote_dly;

  rst_req_ctrl #(
    .NUM_STAGES(NS),
    .MIN_ASSERT(MA),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ack_async(ack_async),
    .rst_out  (rst_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Free-running 100-unit clock.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  function automatic bit modelRstOut();
    return (phase == PH_STRECH) || (phase == PH_WAIT);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep(input bit rst_v, input bit req_v, input bit ack_v);
    bit seen_ack;
    int next_phase;
    if (rst_v) begin
      phase = PH_STRECH;
      age   = 0;
      m_err = 1'b0;
      for (int i = 0; i < NS; i++) m_sync[i] = 1'b0;
    end else begin
      seen_ack = m_sync[NS-1];
      for (int i = NS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = ack_v;
      next_phase = phase;
      case (phase)
        PH_IDLE: begin
          if (req_v) begin
            next_phase = PH_STRECH;
            m_err = 1'b0;
          end
        end
        PH_STRECH: if (age + 1 >= MA) next_phase = PH_WAIT;
        PH_WAIT: begin
          if (seen_ack) next_phase = PH_DROP;
          else if (age + 1 >= TO) begin
            next_phase = PH_DROP;
            m_err = 1'b1;
          end
        end
        PH_DROP: begin
          if (!seen_ack) next_phase = PH_END;
          else if (age + 1 >= TO) begin
            next_phase = PH_IDLE;
            m_err = 1'b1;
          end
        end
        default: next_phase = PH_IDLE;
      endcase
      age   = (next_phase == phase) ? age + 1 : 0;
      phase = next_phase;
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = modelRstOut();
    if (phase == PH_END && !m_err) m_done_cnt = m_done_cnt + 1;
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs with the model.
  task automatic applyStimulus(input bit rst_v, input bit req_v);
    bit ack_v;
    case (remote_mode)
      RM_LOOP:  ack_v = hist[remote_dly];
      RM_LOW:   ack_v = 1'b0;
      RM_HIGH:  ack_v = 1'b1;
      default:  ack_v = 1'($urandom % 2);
    endcase
    rst       = rst_v;
    req       = req_v;
    ack_async = ack_v;
    @(posedge clk);
    modelStep(rst_v, req_v, ack_v);
    cycle = cycle + 1;
    #1;
    if (done === 1'b1) dut_done_cnt = dut_done_cnt + 1;
    checkOutput("rst_out", 32'(rst_out), 32'(modelRstOut()));
    checkOutput("busy", 32'(busy), 32'(phase != PH_IDLE));
    checkOutput("done", 32'(done), 32'(phase == PH_END && !m_err));
    checkOutput("err", 32'(err), 32'(m_err));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    cycle        = 0;
    phase        = PH_IDLE;
    age          = 0;
    m_err        = 1'b0;
    m_done_cnt   = 0;
    dut_done_cnt = 0;
    for (int i = 0; i < NS; i++) m_sync[i] = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    rst       = 1'b1;
    req       = 1'b0;
    ack_async = 1'b0;

    // Power-up with a loopback remote, delay 2.
    remote_mode = RM_LOOP;
    remote_dly  = 2;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    idleCycles(25);

    // Single request pulse in IDLE.
    applyStimulus(1'b0, 1'b1);
    idleCycles(25);

    // Remote never acknowledges, then a clean request clears ERR.
    remote_mode = RM_LOW;
    applyStimulus(1'b0, 1'b1);
    idleCycles(TO + MA + 10);
    remote_mode = RM_LOOP;
    applyStimulus(1'b0, 1'b1);
    idleCycles(25);

    // Remote ack stuck high: release wait times out.
    remote_mode = RM_HIGH;
    applyStimulus(1'b0, 1'b1);
    idleCycles(2 * TO + MA + 10);

    // Requests during an active sequence are ignored.
    remote_mode = RM_LOOP;
    remote_dly  = 1;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'($urandom % 2));
    idleCycles(20);

    // Request held high: back-to-back sequences.
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1);
    idleCycles(20);

    // Local reset while waiting for the acknowledge.
    remote_mode = RM_LOW;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 20 && phase != PH_WAIT; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("reached_wait", 32'(phase == PH_WAIT), 32'd1);
    idleCycles(3);
    remote_mode = RM_LOOP;
    remote_dly  = 2;
    applyStimulus(1'b1, 1'b0);
    idleCycles(25);

    // Randomized requests, resets and remote behaviour.
    for (int seg = 0; seg < 15; seg++) begin
      remote_mode = int'($urandom_range(0, 3));
      remote_dly  = int'($urandom_range(0, 4));
      for (int i = 0; i < 100; i++) begin
        applyStimulus(1'($urandom % 200 == 0), 1'($urandom % 8 == 0));
      end
    end
    remote_mode = RM_LOOP;
    idleCycles(2 * TO + MA + 10);

    checkOutput("done_count", 32'(dut_done_cnt), 32'(m_done_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
